// File: rtl/instruction_fetch_if.sv
// Bundle between the fetch stage, instruction memory, redirect source and decode.
// master = fetch stage, slave = the surrounding core (or a testbench).
interface instruction_fetch_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] imem_address;
  logic [DW-1:0] imem_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_target;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic [AW-1:0] out_pc_plus4;
  logic          fault;
  logic [AW-1:0] fault_addr;
  logic [31:0]   fetch_count;

  modport master (
    output imem_address,
    input  imem_data,
    input  redirect_valid,
    input  redirect_target,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output out_pc_plus4,
    output fault,
    output fault_addr,
    output fetch_count
  );

  modport slave (
    input  imem_address,
    output imem_data,
    output redirect_valid,
    output redirect_target,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  out_pc_plus4,
    input  fault,
    input  fault_addr,
    input  fetch_count
  );
endinterface

// File: rtl/instruction_fetch.sv
// rv32i fetch stage: owns the PC, registers the instruction from a combinational
// instruction memory and hands it to decode over valid/ready; misaligned redirects fault.
module instruction_fetch #(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  instruction_fetch_if.master bus
);

  typedef enum logic {RUN, FAULT} state_t;

  localparam logic [AW-1:0] PC_STEP = AW'(4);

  state_t        state_reg, state_next;
  logic [AW-1:0] pc_reg, pc_next;
  logic          out_valid_reg, out_valid_next;
  logic [DW-1:0] out_instr_reg, out_instr_next;
  logic [AW-1:0] out_pc_reg, out_pc_next;
  logic [AW-1:0] out_pc_plus4_reg, out_pc_plus4_next;
  logic          fault_reg, fault_next;
  logic [AW-1:0] fault_addr_reg, fault_addr_next;
  logic [31:0]   fetch_count_reg, fetch_count_next;

  logic fire;
  logic load;
  logic target_aligned;

  assign fire           = out_valid_reg & bus.out_ready;
  assign load           = (~out_valid_reg | bus.out_ready) & (state_reg == RUN);
  assign target_aligned = (bus.redirect_target[1:0] == 2'b00);

  always_comb begin
    state_next        = state_reg;
    pc_next           = pc_reg;
    out_valid_next    = out_valid_reg;
    out_instr_next    = out_instr_reg;
    out_pc_next       = out_pc_reg;
    out_pc_plus4_next = out_pc_plus4_reg;
    fault_next        = fault_reg;
    fault_addr_next   = fault_addr_reg;
    fetch_count_next  = fetch_count_reg;

    // A handshake always counts, even when a redirect or fault lands in the same cycle.
    if (fire) begin
      fetch_count_next = fetch_count_reg + 32'd1;
    end

    case (state_reg)
      RUN: begin
        if (bus.redirect_valid) begin
          // Whatever memory returned this cycle is on the wrong path: drop it.
          out_valid_next = 1'b0;
          if (target_aligned) begin
            pc_next = bus.redirect_target;
          end else begin
            state_next      = FAULT;
            fault_next      = 1'b1;
            fault_addr_next = bus.redirect_target;
          end
        end else if (load) begin
          out_instr_next    = bus.imem_data;
          out_pc_next       = pc_reg;
          out_pc_plus4_next = pc_reg + PC_STEP;
          out_valid_next    = 1'b1;
          pc_next           = pc_reg + PC_STEP;
        end
      end
      FAULT: begin
        out_valid_next = 1'b0;
      end
      default: begin
        state_next = FAULT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= RUN;
      pc_reg           <= RESET_PC;
      out_valid_reg    <= 1'b0;
      out_instr_reg    <= '0;
      out_pc_reg       <= '0;
      out_pc_plus4_reg <= '0;
      fault_reg        <= 1'b0;
      fault_addr_reg   <= '0;
      fetch_count_reg  <= '0;
    end else begin
      state_reg        <= state_next;
      pc_reg           <= pc_next;
      out_valid_reg    <= out_valid_next;
      out_instr_reg    <= out_instr_next;
      out_pc_reg       <= out_pc_next;
      out_pc_plus4_reg <= out_pc_plus4_next;
      fault_reg        <= fault_next;
      fault_addr_reg   <= fault_addr_next;
      fetch_count_reg  <= fetch_count_next;
    end
  end

  // Memory address comes straight from the PC so the fetch has a full cycle.
  assign bus.imem_address = pc_reg;
  assign bus.out_valid    = out_valid_reg;
  assign bus.out_instr    = out_instr_reg;
  assign bus.out_pc       = out_pc_reg;
  assign bus.out_pc_plus4 = out_pc_plus4_reg;
  assign bus.fault        = fault_reg;
  assign bus.fault_addr   = fault_addr_reg;
  assign bus.fetch_count  = fetch_count_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized scoreboard bench for instruction_fetch: a cycle model predicts each
// cycle's visible outputs, a negedge monitor pops and compares them.
module tb_instruction_fetch;
  localparam int          AW       = 32;
  localparam int          DW       = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic w_rst = 1'b1;
  always #5 clk = ~clk;

  instruction_fetch_if #(.AW(AW), .DW(DW)) bus ();
  instruction_fetch_if #(.AW(AW), .DW(DW)) wbus ();

  instruction_fetch #(.AW(AW), .DW(DW), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .bus(bus.master)
  );
  instruction_fetch #(.AW(AW), .DW(DW), .RESET_PC(WRAP_PC)) u_wrap (
    .clk(clk), .rst(w_rst), .bus(wbus.master)
  );

  // Instruction memory contents as a pure function of the address (0 -> 0x13, a nop).
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign bus.imem_data  = mem_word(bus.imem_address);
  assign wbus.imem_data = mem_word(wbus.imem_address);

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        valid;
    logic        fresh;
    logic [31:0] opc;
    logic [31:0] instr;
    logic [31:0] plus4;
    logic [31:0] imem;
    logic        fault;
    logic [31:0] faddr;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Reference model: what the stage should be showing after each edge.
  bit          tracking = 0;
  logic        m_valid, m_fresh, m_fault;
  logic [31:0] m_pc, m_opc, m_instr, m_faddr, m_cnt;

  // Called 1 time unit after a rising edge: records the expected view for this
  // cycle, applies inputs, then advances the model across the next edge.
  task automatic step(input logic r, input logic rv, input logic [31:0] rt, input logic rdy);
    exp_t e;
    if (tracking) begin
      e.valid = m_valid;
      e.fresh = m_fresh;
      e.opc   = m_opc;
      e.instr = m_instr;
      e.plus4 = m_fresh ? 32'h0 : m_opc + 32'd4;
      e.imem  = m_pc;
      e.fault = m_fault;
      e.faddr = m_faddr;
      e.cnt   = m_cnt;
      sb.push_back(e);
    end
    rst                 = r;
    bus.redirect_valid  = rv;
    bus.redirect_target = rt;
    bus.out_ready       = rdy;
    if (r) begin
      tracking = 1;
      m_pc = RESET_PC; m_valid = 0; m_fresh = 1; m_opc = 0; m_instr = 0;
      m_fault = 0; m_faddr = 0; m_cnt = 0;
    end else begin
      if (m_valid && rdy) m_cnt = m_cnt + 1;
      if (!m_fault) begin
        if (rv) begin
          m_valid = 0;
          if (rt[1:0] == 2'b00) m_pc = rt;
          else begin
            m_fault = 1;
            m_faddr = rt;
          end
        end else if (!m_valid || rdy) begin
          m_opc   = m_pc;
          m_instr = mem_word(m_pc);
          m_valid = 1;
          m_fresh = 0;
          m_pc    = m_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("out_valid", {31'b0, bus.out_valid}, {31'b0, mon_e.valid});
      check("imem_address", bus.imem_address, mon_e.imem);
      check("fault", {31'b0, bus.fault}, {31'b0, mon_e.fault});
      check("fetch_count", bus.fetch_count, mon_e.cnt);
      if (mon_e.fault) check("fault_addr", bus.fault_addr, mon_e.faddr);
      if (mon_e.valid || mon_e.fresh) begin
        check("out_pc", bus.out_pc, mon_e.opc);
        check("out_instr", bus.out_instr, mon_e.instr);
        check("out_pc_plus4", bus.out_pc_plus4, mon_e.plus4);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [31:0] wexp [3];

  initial begin
    logic        r, rv, rdy;
    logic [31:0] rt;
    int          rdy_pct;
    int          n;

    bus.redirect_valid   = 0;
    bus.redirect_target  = 0;
    bus.out_ready        = 0;
    wbus.redirect_valid  = 0;
    wbus.redirect_target = 0;
    wbus.out_ready       = 1;
    @(posedge clk);
    #1;

    // Reset, stream 0/4, stall with out_pc=4, resume, redirect while out_pc=8.
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 1, 32'h40, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    // Misaligned redirect, then everything ignored until reset.
    step(0, 1, 32'h42, 1);
    step(0, 1, 32'h80, 1);
    step(0, 0, 0, 0);
    step(0, 1, 32'h80, 1);
    step(0, 0, 0, 1);
    step(1, 0, 0, 1);
    // Reset in the middle of a stall with a valid instruction held.
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 1);

    rdy_pct = 80;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) rdy_pct = $urandom_range(0, 100);
      r   = ($urandom_range(0, 399) == 0) || (m_fault && ($urandom_range(0, 15) == 0));
      rv  = ($urandom_range(0, 9) == 0);
      rt  = $urandom_range(0, 255) << 2;
      if ($urandom_range(0, 7) == 0) rt = 32'hFFFF_FFE0 | (rt & 32'h1C);
      if ($urandom_range(0, 59) == 0) rt = rt | $urandom_range(1, 3);
      rdy = ($urandom_range(0, 99) < rdy_pct);
      step(r, rv, rt, rdy);
    end
    step(0, 0, 0, 1);
    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);

    // Separate instance whose reset PC sits just below the top of the address space.
    wexp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    @(posedge clk);
    #1;
    w_rst = 0;
    @(negedge clk);
    check("wrap_valid_after_rst", {31'b0, wbus.out_valid}, 32'h0);
    check("wrap_imem_reset", wbus.imem_address, WRAP_PC);
    n = 0;
    for (int i = 0; i < 10 && n < 3; i++) begin
      @(negedge clk);
      if (wbus.out_valid) begin
        check("wrap_out_pc", wbus.out_pc, wexp[n]);
        check("wrap_out_pc_plus4", wbus.out_pc_plus4, wexp[n] + 32'd4);
        check("wrap_out_instr", wbus.out_instr, mem_word(wexp[n]));
        n++;
      end
    end
    check("wrap_count_seen", n, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
